// File: rtl/lcd_scan_writer.sv
// lcd_scan_writer: sweeps generator addresses and streams RGB565 words to an 8080 panel.
// Define LCD_WINDOW_EN to prefix each frame with a full-panel column/page window.
module lcd_scan_writer #(
  parameter int WIDTH = 240,
  parameter int HEIGHT = 320,
  parameter int PIXEL_LATENCY = 2,
  parameter int INIT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        globalReset,
  input  logic        enable,
  input  logic [15:0] pixelData,
  output logic [9:0]  xAddLCD,
  output logic [8:0]  yAddLCD,
  output logic        LCD_CS_n,
  output logic        LCD_RS,
  output logic        LCD_WR_n,
  output logic        LCD_RD_n,
  output logic [15:0] LCD_DATA,
  output logic        frameDone
);
  localparam int CW = $clog2(INIT_CYCLES + 8);
  localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);
`ifdef LCD_WINDOW_EN
  localparam int NCMD = 11;
  localparam logic [15:0] XW = 16'(WIDTH - 1);
  localparam logic [15:0] YW = 16'(HEIGHT - 1);
`else
  localparam int NCMD = 1;
`endif
  localparam logic [3:0] CMD_LAST = 4'(NCMD - 1);

  typedef enum logic [2:0] {
    INIT, IDLE, CMD, ADDR, WR_LO, WR_HI
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    cmdIdx;
  logic          cmdPhase;
  logic [16:0]   cmdWord;

  // {RS, data} of the command-list word at cmdIdx
  always_comb begin
    cmdWord = {1'b0, 16'h002C};
`ifdef LCD_WINDOW_EN
    case (cmdIdx)
      4'd0:       cmdWord = {1'b0, 16'h002A};
      4'd1, 4'd2: cmdWord = {1'b1, 16'h0000};
      4'd3:       cmdWord = {1'b1, 8'h00, XW[15:8]};
      4'd4:       cmdWord = {1'b1, 8'h00, XW[7:0]};
      4'd5:       cmdWord = {1'b0, 16'h002B};
      4'd6, 4'd7: cmdWord = {1'b1, 16'h0000};
      4'd8:       cmdWord = {1'b1, 8'h00, YW[15:8]};
      4'd9:       cmdWord = {1'b1, 8'h00, YW[7:0]};
      default:    cmdWord = {1'b0, 16'h002C};
    endcase
`endif
  end

  assign LCD_RD_n = 1'b1;

  always_ff @(posedge clock) begin
    if (!globalReset) begin
      state     <= INIT;
      cnt       <= '0;
      cmdIdx    <= '0;
      cmdPhase  <= 1'b0;
      xAddLCD   <= '0;
      yAddLCD   <= '0;
      LCD_DATA  <= '0;
      LCD_CS_n  <= 1'b1;
      LCD_RS    <= 1'b1;
      LCD_WR_n  <= 1'b1;
      frameDone <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      case (state)
        INIT: begin
          if (cnt == CW'(INIT_CYCLES - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        IDLE: begin
          LCD_CS_n <= ~enable;
          if (enable) begin
            cmdIdx   <= '0;
            cmdPhase <= 1'b0;
            state    <= CMD;
          end
        end
        CMD: begin
          if (!cmdPhase) begin
            LCD_DATA <= cmdWord[15:0];
            LCD_RS   <= cmdWord[16];
            LCD_WR_n <= 1'b0;
            cmdPhase <= 1'b1;
          end else begin
            LCD_WR_n <= 1'b1;
            cmdPhase <= 1'b0;
            if (cmdIdx == CMD_LAST) begin
              xAddLCD <= '0;
              yAddLCD <= '0;
              cnt     <= '0;
              state   <= ADDR;
            end else begin
              cmdIdx <= cmdIdx + 4'd1;
            end
          end
        end
        ADDR: begin
          if (cnt == CW'(PIXEL_LATENCY - 1)) begin
            cnt   <= '0;
            state <= WR_LO;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WR_LO: begin
          LCD_DATA <= pixelData;
          LCD_RS   <= 1'b1;
          LCD_WR_n <= 1'b0;
          state    <= WR_HI;
        end
        WR_HI: begin
          LCD_WR_n <= 1'b1;
          if (xAddLCD != X_LAST) begin
            xAddLCD <= xAddLCD + 10'd1;
            state   <= ADDR;
          end else if (yAddLCD != Y_LAST) begin
            xAddLCD <= '0;
            yAddLCD <= yAddLCD + 9'd1;
            state   <= ADDR;
          end else begin
            xAddLCD   <= '0;
            yAddLCD   <= '0;
            frameDone <= 1'b1;
            LCD_CS_n  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_scan_writer.sv
// tb_lcd_scan_writer: frame-timeline model plus directed checks for lcd_scan_writer.
// Panel height is reduced so several complete frames fit in a short run.
module tb_lcd_scan_writer;
  localparam int W = 240;
  localparam int H = 8;
  localparam int LAT = 2;
  localparam int INITC = 16;
`ifdef LCD_WINDOW_EN
  localparam int NCMD = 11;
`else
  localparam int NCMD = 1;
`endif
  localparam int NPIX = W * H;
  localparam int FLEN = 2 * NCMD + 4 * NPIX;

  logic        clock = 1'b0;
  logic        globalReset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] pixelData;
  logic [9:0]  xAddLCD;
  logic [8:0]  yAddLCD;
  logic        LCD_CS_n, LCD_RS, LCD_WR_n, LCD_RD_n, frameDone;
  logic [15:0] LCD_DATA;

  int tests = 0;
  int fails = 0;

  lcd_scan_writer #(
    .WIDTH(W), .HEIGHT(H), .PIXEL_LATENCY(LAT), .INIT_CYCLES(INITC)
  ) dut (
    .clock(clock), .globalReset(globalReset), .enable(enable),
    .pixelData(pixelData), .xAddLCD(xAddLCD), .yAddLCD(yAddLCD),
    .LCD_CS_n(LCD_CS_n), .LCD_RS(LCD_RS), .LCD_WR_n(LCD_WR_n),
    .LCD_RD_n(LCD_RD_n), .LCD_DATA(LCD_DATA), .frameDone(frameDone)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] pix(int x, int y);
    logic [15:0] v;
    v = 16'(x) | (16'(y) << 10);
    return 16'hF800 ^ v;
  endfunction

  function automatic logic [16:0] cmdW(int k);
    logic [15:0] xl, yl;
    xl = 16'(W - 1);
    yl = 16'(H - 1);
    if (k == NCMD - 1) return {1'b0, 16'h002C};
    case (k)
      0: return {1'b0, 16'h002A};
      3: return {1'b1, 8'h00, xl[15:8]};
      4: return {1'b1, 8'h00, xl[7:0]};
      5: return {1'b0, 16'h002B};
      8: return {1'b1, 8'h00, yl[15:8]};
      9: return {1'b1, 8'h00, yl[7:0]};
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  // Generator stand-in with a two-cycle address-to-data latency
  logic [15:0] g1;
  always @(posedge clock) begin
    g1 <= pix(int'(xAddLCD), int'(yAddLCD));
    pixelData <= g1;
  end

  // Timeline model: mode 0 init, 1 idle, 2 frame (mT = edges since CMD entry)
  int mMode = 0, mT = 0, eX = 0, eY = 0;
  logic [15:0] eData = '0;
  logic eRS = 1'b1, eCS = 1'b1, eWR = 1'b1, eFD = 1'b0;
  logic cmpOn = 1'b0;
  int cyc = 0;

  always @(posedge clock) begin
    int u, p, ph, q;
    logic [16:0] cw;
    logic done;
    cyc++;
    done = 1'b0;
    if (!globalReset) begin
      mMode = 0; mT = 0; eData = '0; eRS = 1'b1;
    end else begin
      case (mMode)
        0: begin mT++; if (mT == INITC) mMode = 1; end
        1: if (enable) begin mMode = 2; mT = 0; end
        default: begin
          mT++;
          if (mT == FLEN) begin mMode = 1; done = 1'b1; end
        end
      endcase
    end
    eCS = 1'b1; eWR = 1'b1; eFD = done; eX = 0; eY = 0;
    if (mMode == 2) begin
      eCS = 1'b0;
      if (mT >= 1 && mT <= 2 * NCMD) begin
        cw = cmdW((mT - 1) / 2);
        eWR = ((mT - 1) % 2 == 0) ? 1'b0 : 1'b1;
        eData = cw[15:0];
        eRS = cw[16];
      end else if (mT > 2 * NCMD) begin
        u = mT - 2 * NCMD - 1;
        p = u / 4;
        ph = u % 4;
        eWR = (ph == 2) ? 1'b0 : 1'b1;
        if (ph >= 2) begin eData = pix(p % W, p / W); eRS = 1'b1; end
        q = (ph == 3) ? p + 1 : p;
        eX = q % W;
        eY = q / W;
      end
    end
  end

  initial begin
    @(posedge clock);
    cmpOn = 1'b1;
  end

  always @(negedge clock) begin
    logic [39:0] act, exp;
    if (cmpOn) begin
      act = {LCD_CS_n, LCD_RS, LCD_WR_n, LCD_RD_n, frameDone,
             LCD_DATA, xAddLCD, yAddLCD};
      exp = {eCS, eRS, eWR, 1'b1, eFD, eData, 10'(eX), 9'(eY)};
      tests++;
      if (act !== exp) begin
        fails++;
        if (fails <= 20)
          $display("FAIL cycle_model cyc=%0d got %h expected %h", cyc, act, exp);
      end
    end
  end

  // Panel-side capture of every write strobe
  logic [15:0] wrData[$];
  logic        wrRS[$];
  int          wrX[$], wrY[$], wrCyc[$];
  logic        prevWr = 1'b1;
  always @(negedge clock) begin
    if (LCD_WR_n === 1'b0 && prevWr === 1'b1) begin
      wrData.push_back(LCD_DATA);
      wrRS.push_back(LCD_RS);
      wrX.push_back(int'(xAddLCD));
      wrY.push_back(int'(yAddLCD));
      wrCyc.push_back(cyc);
    end
    prevWr = LCD_WR_n;
  end

  task automatic chk(string nm, logic [39:0] act, logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic waitFd(int lim, string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clock);
      if (frameDone === 1'b1) seen = 1;
    end
    chk(nm, 40'(seen), 40'd1);
  endtask

  logic [15:0] litD[11];
  logic        litR[11];

  initial begin
    int n, bad, w2, w3, idx;
    bit hit;
`ifdef LCD_WINDOW_EN
    litD = '{16'h2A, 16'h0, 16'h0, 16'h0, 16'hEF, 16'h2B,
             16'h0, 16'h0, 16'h0, 16'h07, 16'h2C};
    litR = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
             1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    litD = '{default: 16'h0};
    litR = '{default: 1'b1};
    litD[0] = 16'h002C;
    litR[0] = 1'b0;
`endif
    globalReset = 1'b0;
    enable = 1'b1;
    repeat (5) @(negedge clock);
    chk("rst_cs", 40'(LCD_CS_n), 40'd1);
    chk("rst_wr", 40'(LCD_WR_n), 40'd1);
    chk("rst_rs", 40'(LCD_RS), 40'd1);
    chk("rst_rd", 40'(LCD_RD_n), 40'd1);
    chk("rst_data", 40'(LCD_DATA), 40'd0);
    chk("rst_xy", 40'({xAddLCD, yAddLCD}), 40'd0);
    chk("rst_fd", 40'(frameDone), 40'd0);

    globalReset = 1'b1;
    n = 0;
    hit = 0;
    for (int i = 1; i <= 40 && !hit; i++) begin
      @(negedge clock);
      if (LCD_CS_n === 1'b0) begin hit = 1; n = i; end
    end
    chk("cs_fall_edge", 40'(n), 40'd17);

    waitFd(FLEN + 100, "frame1_done");
    chk("frame1_writes", 40'(wrData.size()), 40'(NCMD + NPIX));
    for (int i = 0; i < NCMD; i++) begin
      chk("cmd_word", 40'(wrData[i]), 40'(litD[i]));
      chk("cmd_rs", 40'(wrRS[i]), 40'(litR[i]));
    end
    chk("pix0_data", 40'(wrData[NCMD]), 40'hF800);
    chk("pix0_rs", 40'(wrRS[NCMD]), 40'd1);
    chk("pix0_xy", 40'(wrX[NCMD] + wrY[NCMD]), 40'd0);
    idx = NCMD + 5 * W + 239;
    chk("wrap_prev_x", 40'(wrX[idx]), 40'd239);
    chk("wrap_prev_y", 40'(wrY[idx]), 40'd5);
    chk("wrap_next_x", 40'(wrX[idx + 1]), 40'd0);
    chk("wrap_next_y", 40'(wrY[idx + 1]), 40'd6);
    chk("wrap_next_data", 40'(wrData[idx + 1]), 40'hE000);
    bad = 0;
    for (int i = NCMD + 1; i < NCMD + NPIX; i++)
      if (wrCyc[i] - wrCyc[i - 1] != 4) bad++;
    chk("pix_spacing_bad", 40'(bad), 40'd0);
    @(negedge clock);
    chk("fd_width", 40'(frameDone), 40'd0);
    chk("next_frame_cs", 40'(LCD_CS_n), 40'd0);

    repeat (1000) @(negedge clock);
    enable = 1'b0;
    waitFd(FLEN + 100, "frame2_done");
    w2 = wrData.size();
    chk("frame2_writes", 40'(w2), 40'(2 * (NCMD + NPIX)));
    bad = 0;
    repeat (300) begin
      @(negedge clock);
      if (LCD_CS_n !== 1'b1) bad++;
    end
    chk("idle_cs_bad", 40'(bad), 40'd0);
    chk("idle_no_strobe", 40'(wrData.size()), 40'(w2));

    enable = 1'b1;
    hit = 0;
    for (int i = 0; i < FLEN + 400 && !hit; i++) begin
      @(negedge clock);
      if (mMode == 2 && mT == 2 * NCMD + 4 * (5 * W + 100) + 3) hit = 1;
    end
    chk("abort_point", 40'(hit), 40'd1);
    chk("abort_wr_low", 40'(LCD_WR_n), 40'd0);
    chk("abort_xy", 40'({xAddLCD, yAddLCD}), 40'({10'd100, 9'd5}));
    globalReset = 1'b0;
    @(negedge clock);
    chk("abort_cs", 40'(LCD_CS_n), 40'd1);
    chk("abort_wr", 40'(LCD_WR_n), 40'd1);
    chk("abort_x", 40'(xAddLCD), 40'd0);
    chk("abort_y", 40'(yAddLCD), 40'd0);
    repeat (2) @(negedge clock);
    globalReset = 1'b1;
    w3 = wrData.size();
    waitFd(INITC + FLEN + 100, "frame3_done");
    chk("frame3_writes", 40'(wrData.size() - w3), 40'(NCMD + NPIX));
    chk("frame3_first", 40'(wrData[w3]), 40'(litD[0]));
    chk("frame3_first_rs", 40'(wrRS[w3]), 40'(litR[0]));
    chk("frame3_last_cmd", 40'(wrData[w3 + NCMD - 1]), 40'h002C);
    chk("frame3_pix0", 40'(wrData[w3 + NCMD]), 40'hF800);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
